glb_banked: RTL and testbench

Parametrised, banked global buffer for the accelerator datapath. It holds separate weight, activation and partial-sum banks, each of DEPTH entries, and serves a single-cycle registered fetch of all three. A pipelined read-modify-write port accumulates partial sums in place, with same-address forwarding. A clear engine zeroes the psum bank between layers. It sits between the host/loader and the PE array, replacing the flat 8-bit shared buffer.

---
 rtl/glb_banked_if.sv | 49 ++++
 rtl/glb_banked.sv | 147 ++++++++++++++
 tb/tb_glb_banked.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/glb_banked_if.sv
// Bus bundle for glb_banked: load, fetch, accumulate and clear-control signals.
// The host/PE side uses the master modport and the buffer uses the slave modport.
interface glb_if #(
    parameter int DATA_W = 8,
    parameter int PSUM_W = 32,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = $clog2(DEPTH)
);
    logic                     ld_valid;
    logic                     ld_ready;
    logic [1:0]               ld_bank;
    logic [ADDR_W-1:0]        ld_addr;
    logic [PSUM_W-1:0]        ld_data;

    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr_w;
    logic [ADDR_W-1:0]        rd_addr_a;
    logic [ADDR_W-1:0]        rd_addr_p;
    logic [DATA_W-1:0]        weight;
    logic [DATA_W-1:0]        activation;
    logic signed [PSUM_W-1:0] partial_sum;
    logic                     rd_valid;

    logic                     acc_valid;
    logic                     acc_ready;
    logic [ADDR_W-1:0]        acc_addr;
    logic signed [PSUM_W-1:0] acc_data;
    logic                     acc_done;

    logic                     clr_start;
    logic                     busy;
    logic                     err;

    modport master (
        output ld_valid, ld_bank, ld_addr, ld_data,
        output rd_en, rd_addr_w, rd_addr_a, rd_addr_p,
        output acc_valid, acc_addr, acc_data, clr_start,
        input  ld_ready, weight, activation, partial_sum, rd_valid,
        input  acc_ready, acc_done, busy, err
    );

    modport slave (
        input  ld_valid, ld_bank, ld_addr, ld_data,
        input  rd_en, rd_addr_w, rd_addr_a, rd_addr_p,
        input  acc_valid, acc_addr, acc_data, clr_start,
        output ld_ready, weight, activation, partial_sum, rd_valid,
        output acc_ready, acc_done, busy, err
    );
endinterface

// File: rtl/glb_banked.sv
// Banked global buffer: weight/activation/psum banks, registered fetch, 2-stage psum RMW, clear engine.
// Define GLB_PSUM_SAT_EN to saturate accumulate sums instead of wrapping.
module glb_banked #(
    parameter int DATA_W = 8,
    parameter int PSUM_W = 32,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input logic clk,
    input logic rst_n,
    glb_if.slave bus
);
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0]        w_mem [DEPTH];
    logic [DATA_W-1:0]        a_mem [DEPTH];
    logic signed [PSUM_W-1:0] p_mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    logic [DATA_W-1:0]        weight_q;
    logic [DATA_W-1:0]        activation_q;
    logic signed [PSUM_W-1:0] psum_q;
    logic                     rd_valid_q;
    logic                     err_q;

    logic                     s1_vld_q;
    logic [ADDR_W-1:0]        s1_addr_q;
    logic signed [PSUM_W-1:0] s1_data_q;
    logic signed [PSUM_W-1:0] s1_rd_q;
    logic                     s2_vld_q;
    logic [ADDR_W-1:0]        s2_addr_q;
    logic signed [PSUM_W-1:0] s2_sum_q;

    logic                     clearing;
    logic                     pipe_busy;
    logic                     ld_fire;
    logic                     acc_fire;
    logic                     clr_go;
    logic signed [PSUM_W-1:0] s1_operand;
    logic signed [PSUM_W-1:0] s1_sum;

    function automatic logic signed [PSUM_W-1:0] psum_add(
        input logic signed [PSUM_W-1:0] a,
        input logic signed [PSUM_W-1:0] b
    );
        logic signed [PSUM_W:0]   wide;
        logic signed [PSUM_W-1:0] res;
        wide = (PSUM_W+1)'(a) + (PSUM_W+1)'(b);
        res  = wide[PSUM_W-1:0];
`ifdef GLB_PSUM_SAT_EN
        if (wide[PSUM_W] != wide[PSUM_W-1])
            res = wide[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}};
`endif
        return res;
    endfunction

    assign clearing  = (state_q == CLEAR);
    assign pipe_busy = s1_vld_q | s2_vld_q;
    assign ld_fire   = bus.ld_valid & bus.ld_ready;
    assign acc_fire  = bus.acc_valid & bus.acc_ready;
    // An accumulate arriving in the same cycle also blocks the clear so the RMW and clear never share the psum port.
    assign clr_go    = !clearing && bus.clr_start && !pipe_busy && !bus.acc_valid;

    assign s1_operand = (s2_vld_q && (s2_addr_q == s1_addr_q)) ? s2_sum_q : s1_rd_q;
    assign s1_sum     = psum_add(s1_operand, s1_data_q);

    assign bus.ld_ready    = !((bus.ld_bank == 2'd2) && (clearing || pipe_busy || bus.acc_valid));
    assign bus.acc_ready   = !clearing;
    assign bus.weight      = weight_q;
    assign bus.activation  = activation_q;
    assign bus.partial_sum = psum_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.acc_done    = s2_vld_q;
    assign bus.busy        = clearing;
    assign bus.err         = err_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (clr_go) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                if (idx_q == LAST_IDX) state_d = IDLE;
                else                   idx_d   = idx_q + ADDR_W'(1);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            weight_q     <= '0;
            activation_q <= '0;
            psum_q       <= '0;
            rd_valid_q   <= 1'b0;
            err_q        <= 1'b0;
            s1_vld_q     <= 1'b0;
            s2_vld_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                weight_q     <= w_mem[bus.rd_addr_w];
                activation_q <= a_mem[bus.rd_addr_a];
                psum_q       <= p_mem[bus.rd_addr_p];
            end
            if (ld_fire && (bus.ld_bank == 2'd3)) err_q <= 1'b1;
            s1_vld_q <= acc_fire;
            s2_vld_q <= s1_vld_q;
        end
    end

    // Stage 1 captures operand and memory read; stage 2 holds the written sum for forwarding.
    always_ff @(posedge clk) begin
        if (acc_fire) begin
            s1_addr_q <= bus.acc_addr;
            s1_data_q <= bus.acc_data;
            s1_rd_q   <= p_mem[bus.acc_addr];
        end
        if (s1_vld_q) begin
            s2_addr_q <= s1_addr_q;
            s2_sum_q  <= s1_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (clearing)
            p_mem[idx_q] <= '0;
        else if (s1_vld_q)
            p_mem[s1_addr_q] <= s1_sum;
        else if (ld_fire && (bus.ld_bank == 2'd2))
            p_mem[bus.ld_addr] <= bus.ld_data;
        if (ld_fire && (bus.ld_bank == 2'd0)) w_mem[bus.ld_addr] <= bus.ld_data[DATA_W-1:0];
        if (ld_fire && (bus.ld_bank == 2'd1)) a_mem[bus.ld_addr] <= bus.ld_data[DATA_W-1:0];
    end
endmodule

// File: tb/tb_glb_banked.sv
// Directed bench for glb_banked: load/fetch, forwarding accumulate, saturation/wrap, clear, error and reset.
module tb_glb_banked;
    localparam int DATA_W = 8;
    localparam int PSUM_W = 32;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    glb_if #(.DATA_W(DATA_W), .PSUM_W(PSUM_W), .DEPTH(DEPTH)) bus ();

    glb_banked #(.DATA_W(DATA_W), .PSUM_W(PSUM_W), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.ld_valid  = 1'b0;
        bus.ld_bank   = 2'd0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
        bus.rd_en     = 1'b0;
        bus.rd_addr_w = '0;
        bus.rd_addr_a = '0;
        bus.rd_addr_p = '0;
        bus.acc_valid = 1'b0;
        bus.acc_addr  = '0;
        bus.acc_data  = '0;
        bus.clr_start = 1'b0;
    endtask

    task automatic do_load(input logic [1:0] b, input logic [ADDR_W-1:0] a, input logic [PSUM_W-1:0] d);
        bus.ld_valid = 1'b1;
        bus.ld_bank  = b;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        bus.ld_bank  = 2'd0;
    endtask

    task automatic do_fetch(input logic [ADDR_W-1:0] aw, input logic [ADDR_W-1:0] aa, input logic [ADDR_W-1:0] ap);
        bus.rd_en     = 1'b1;
        bus.rd_addr_w = aw;
        bus.rd_addr_a = aa;
        bus.rd_addr_p = ap;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.weight !== 8'h00) begin errors++; $display("FAIL reset_weight got %h expected 00", bus.weight); end
        checks++; if (bus.activation !== 8'h00) begin errors++; $display("FAIL reset_activation got %h expected 00", bus.activation); end
        checks++; if (bus.partial_sum !== 32'h0) begin errors++; $display("FAIL reset_psum got %h expected 0", bus.partial_sum); end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b expected 0", bus.rd_valid); end
        checks++; if (bus.acc_done !== 1'b0) begin errors++; $display("FAIL reset_acc_done got %b expected 0", bus.acc_done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b expected 0", bus.err); end
        checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready got %b expected 1", bus.ld_ready); end
        checks++; if (bus.acc_ready !== 1'b1) begin errors++; $display("FAIL reset_acc_ready got %b expected 1", bus.acc_ready); end
    endtask

    task automatic test_fetch();
        do_load(2'd0, 7'd5, 32'h3C);
        do_load(2'd1, 7'd9, 32'hA5);
        do_load(2'd2, 7'd2, 32'h100);
        bus.rd_en = 1'b1; bus.rd_addr_w = 7'd5; bus.rd_addr_a = 7'd9; bus.rd_addr_p = 7'd2;
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL fetch_valid_early got %b expected 0", bus.rd_valid); end
        @(negedge clk);
        bus.rd_en = 1'b0;
        checks++; if (bus.weight !== 8'h3C) begin errors++; $display("FAIL fetch_weight got %h expected 3c", bus.weight); end
        checks++; if (bus.activation !== 8'hA5) begin errors++; $display("FAIL fetch_activation got %h expected a5", bus.activation); end
        checks++; if (bus.partial_sum !== 32'h100) begin errors++; $display("FAIL fetch_psum got %h expected 00000100", bus.partial_sum); end
        checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL fetch_rd_valid got %b expected 1", bus.rd_valid); end
        @(negedge clk);
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL fetch_valid_drop got %b expected 0", bus.rd_valid); end
        checks++; if (bus.weight !== 8'h3C) begin errors++; $display("FAIL fetch_hold got %h expected 3c", bus.weight); end
        // same-cycle write and read of weight[5]
        bus.ld_valid = 1'b1; bus.ld_bank = 2'd0; bus.ld_addr = 7'd5; bus.ld_data = 32'h11;
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        checks++; if (bus.weight !== 8'h3C) begin errors++; $display("FAIL read_first got %h expected 3c", bus.weight); end
        @(negedge clk);
        bus.rd_en = 1'b0;
        checks++; if (bus.weight !== 8'h11) begin errors++; $display("FAIL read_after_write got %h expected 11", bus.weight); end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        do_load(2'd2, 7'd7, 32'd10);
        bus.ld_bank = 2'd2;
        bus.acc_valid = 1'b1; bus.acc_addr = 7'd7; bus.acc_data = 32'sd1;
        @(negedge clk);
        checks++; if (bus.acc_done !== 1'b0) begin errors++; $display("FAIL acc_done_early got %b expected 0", bus.acc_done); end
        checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL acc_blocks_psum_load got %b expected 0", bus.ld_ready); end
        bus.acc_data = 32'sd2;
        @(negedge clk);
        if (bus.acc_done === 1'b1) pulses++;
        bus.acc_data = 32'sd3;
        @(negedge clk);
        if (bus.acc_done === 1'b1) pulses++;
        bus.acc_valid = 1'b0;
        @(negedge clk);
        if (bus.acc_done === 1'b1) pulses++;
        bus.rd_en = 1'b1; bus.rd_addr_p = 7'd7;
        @(negedge clk);
        bus.rd_en = 1'b0;
        checks++; if (pulses !== 3) begin errors++; $display("FAIL acc_done_pulses got %0d expected 3", pulses); end
        checks++; if (bus.acc_done !== 1'b0) begin errors++; $display("FAIL acc_done_end got %b expected 0", bus.acc_done); end
        checks++; if (bus.partial_sum !== 32'd16) begin errors++; $display("FAIL acc_forward_sum got %0d expected 16", bus.partial_sum); end
        checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL psum_load_ready_after got %b expected 1", bus.ld_ready); end
        bus.ld_bank = 2'd0;
    endtask

    task automatic test_saturate();
        logic [PSUM_W-1:0] exp0, exp1;
`ifdef GLB_PSUM_SAT_EN
        exp0 = 32'h7FFFFFFF; exp1 = 32'h80000000;
`else
        exp0 = 32'h80000010; exp1 = 32'h7FFFFFF0;
`endif
        do_load(2'd2, 7'd0, 32'h7FFFFFF0);
        do_load(2'd2, 7'd1, 32'h80000010);
        bus.acc_valid = 1'b1; bus.acc_addr = 7'd0; bus.acc_data = 32'sh20;
        @(negedge clk);
        bus.acc_addr = 7'd1; bus.acc_data = 32'shFFFFFFE0;
        @(negedge clk);
        bus.acc_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        do_fetch(7'd0, 7'd0, 7'd0);
        checks++; if (bus.partial_sum !== exp0) begin errors++; $display("FAIL acc_pos_limit got %h expected %h", bus.partial_sum, exp0); end
        do_fetch(7'd0, 7'd0, 7'd1);
        checks++; if (bus.partial_sum !== exp1) begin errors++; $display("FAIL acc_neg_limit got %h expected %h", bus.partial_sum, exp1); end
    endtask

    task automatic test_clear();
        int cnt, bad_acc, bad_ld, nz;
        bit done;
        cnt = 0; bad_acc = 0; bad_ld = 0; nz = 0; done = 1'b0;
        for (int i = 0; i < DEPTH; i++) do_load(2'd2, ADDR_W'(i), 32'(i + 1));
        bus.ld_bank = 2'd2;
        bus.clr_start = 1'b1;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) done = 1'b1;
            else begin
                cnt++;
                if (bus.acc_ready !== 1'b0) bad_acc++;
                if (k == 11) begin
                    checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL clear_weight_ready got %b expected 1", bus.ld_ready); end
                end else if (bus.ld_ready !== 1'b0) bad_ld++;
                bus.clr_start = (k == 20);
                if (k == 10) begin
                    bus.ld_valid = 1'b1; bus.ld_bank = 2'd0; bus.ld_addr = 7'd3; bus.ld_data = 32'h77;
                end else begin
                    bus.ld_valid = 1'b0; bus.ld_bank = 2'd2;
                end
            end
        end
        bus.ld_valid = 1'b0; bus.ld_bank = 2'd0; bus.clr_start = 1'b0;
        checks++; if (cnt !== DEPTH) begin errors++; $display("FAIL clear_busy_cycles got %0d expected %0d", cnt, DEPTH); end
        checks++; if (bad_acc !== 0) begin errors++; $display("FAIL clear_acc_ready_low got %0d bad cycles expected 0", bad_acc); end
        checks++; if (bad_ld !== 0) begin errors++; $display("FAIL clear_psum_ld_ready_low got %0d bad cycles expected 0", bad_ld); end
        checks++; if (bus.acc_ready !== 1'b1) begin errors++; $display("FAIL clear_acc_ready_after got %b expected 1", bus.acc_ready); end
        for (int i = 0; i < DEPTH; i++) begin
            do_fetch(7'd0, 7'd0, ADDR_W'(i));
            if (bus.partial_sum !== 32'h0) nz++;
        end
        checks++; if (nz !== 0) begin errors++; $display("FAIL clear_psum_zero got %0d nonzero expected 0", nz); end
        do_fetch(7'd3, 7'd0, 7'd0);
        checks++; if (bus.weight !== 8'h77) begin errors++; $display("FAIL clear_weight_load got %h expected 77", bus.weight); end
    endtask

    task automatic test_err();
        do_load(2'd3, 7'd2, 32'hDEADBEEF);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_set got %b expected 1", bus.err); end
        do_load(2'd3, 7'd5, 32'hDEADBEEF);
        do_load(2'd3, 7'd9, 32'hDEADBEEF);
        repeat (3) @(negedge clk);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b expected 1", bus.err); end
        do_fetch(7'd5, 7'd9, 7'd2);
        checks++; if (bus.weight !== 8'h11) begin errors++; $display("FAIL err_weight_unchanged got %h expected 11", bus.weight); end
        checks++; if (bus.activation !== 8'hA5) begin errors++; $display("FAIL err_act_unchanged got %h expected a5", bus.activation); end
        checks++; if (bus.partial_sum !== 32'h0) begin errors++; $display("FAIL err_psum_unchanged got %h expected 0", bus.partial_sum); end
    endtask

    task automatic test_reset_mid_clear();
        bus.rd_en = 1'b1; bus.rd_addr_w = 7'd5; bus.rd_addr_a = 7'd9; bus.rd_addr_p = 7'd2;
        bus.ld_bank = 2'd2;
        bus.clr_start = 1'b1;
        @(negedge clk);
        bus.clr_start = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midclr_busy_before got %b expected 1", bus.busy); end
        checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL midclr_rd_valid_before got %b expected 1", bus.rd_valid); end
        #2;
        rst_n = 1'b0;
        bus.rd_en = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midclr_busy got %b expected 0", bus.busy); end
        checks++; if (bus.weight !== 8'h00) begin errors++; $display("FAIL midclr_weight got %h expected 00", bus.weight); end
        checks++; if (bus.activation !== 8'h00) begin errors++; $display("FAIL midclr_activation got %h expected 00", bus.activation); end
        checks++; if (bus.partial_sum !== 32'h0) begin errors++; $display("FAIL midclr_psum got %h expected 0", bus.partial_sum); end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL midclr_rd_valid got %b expected 0", bus.rd_valid); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL midclr_err got %b expected 0", bus.err); end
        checks++; if (bus.acc_ready !== 1'b1) begin errors++; $display("FAIL midclr_acc_ready got %b expected 1", bus.acc_ready); end
        checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL midclr_ld_ready got %b expected 1", bus.ld_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midclr_idle_after got %b expected 0", bus.busy); end
        bus.ld_bank = 2'd0;
    endtask

    initial begin
        idle_inputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_fetch();
        test_back_to_back();
        test_saturate();
        test_clear();
        test_err();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
